// File: rtl/reg_file_ctrl.sv
// Command sequencer in front of the 16x8 register file: turns READ/WRITE/SET/CLR
// commands into register-file cycles, doing read-modify-write internally.
module reg_file_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              busy
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ISSUE   = 3'd1;
    localparam logic [2:0] CAPTURE = 3'd2;
    localparam logic [2:0] MODIFY  = 3'd3;
    localparam logic [2:0] RESP    = 3'd4;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLR   = 2'b11;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] modified;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // data_q holds the pre-operation value (or the write echo) for the response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_op;
                        addr_q  <= cmd_addr;
                        wdata_q <= cmd_wdata;
                    end
                end
                ISSUE: begin
                    if (op_q == OP_WRITE) begin
                        data_q <= wdata_q;
                    end
                end
                CAPTURE: begin
                    data_q <= rf_rdata;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = (op_q == OP_WRITE) ? RESP : CAPTURE;
            CAPTURE: state_nxt = (op_q == OP_READ) ? RESP : MODIFY;
            MODIFY:  state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign modified = (op_q == OP_SET) ? (data_q | wdata_q) : (data_q & ~wdata_q);

    // Every output decodes from registered state only, so rf_we drops with reset
    always_comb begin
        rf_we    = 1'b0;
        rf_wdata = '0;
        case (state)
            ISSUE: begin
                if (op_q == OP_WRITE) begin
                    rf_we    = 1'b1;
                    rf_wdata = wdata_q;
                end
            end
            MODIFY: begin
                rf_we    = 1'b1;
                rf_wdata = modified;
            end
            default: begin
            end
        endcase
    end

    assign rf_addr   = addr_q;
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = (state == RESP) ? data_q : '0;

endmodule
